// File: rtl/sfp_tx_arbiter.sv
// rtl/sfp_tx_arbiter.sv - two-source frame arbiter onto the SFP TX stream
// Peer frames have priority; local telemetry is granted after STARVE_LIMIT consecutive peer frames.
module sfp_tx_arbiter #(
  parameter int STARVE_LIMIT    = 4,
  parameter int MAX_FRAME_WORDS = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sfp_en,
  input  logic        i_err_clr,
  input  logic [63:0] s_peer_tdata,
  input  logic        s_peer_tvalid,
  input  logic        s_peer_tlast,
  output logic        s_peer_tready,
  input  logic [63:0] s_local_tdata,
  input  logic        s_local_tvalid,
  input  logic        s_local_tlast,
  output logic        s_local_tready,
  output logic [63:0] m_tx_sfp_tdata,
  output logic        m_tx_sfp_tvalid,
  output logic        m_tx_sfp_tlast,
  input  logic        m_tx_sfp_tready,
  output logic [15:0] o_peer_frame_cnt,
  output logic [15:0] o_local_frame_cnt,
  output logic        o_err_long,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEER  = 2'd1,
    ST_LOCAL = 2'd2
  } state_t;

  localparam int            SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [4:0]    WORD_LAST  = 5'(MAX_FRAME_WORDS - 1);

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [4:0]    word_cnt_q, word_cnt_d;
  logic [63:0]   tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;
  logic [15:0]   peer_cnt_q, peer_cnt_d;
  logic [15:0]   local_cnt_q, local_cnt_d;
  logic          err_q, err_d;

  logic        out_free;
  logic        peer_hs, local_hs, hs;
  logic [63:0] src_data;
  logic        src_last, at_limit, frame_end, trunc;

  assign out_free       = !tvalid_q || m_tx_sfp_tready;
  assign s_peer_tready  = (state_q == ST_PEER) && out_free;
  assign s_local_tready = (state_q == ST_LOCAL) && out_free;
  assign peer_hs        = s_peer_tvalid && s_peer_tready;
  assign local_hs       = s_local_tvalid && s_local_tready;
  assign hs             = peer_hs || local_hs;
  assign src_data       = peer_hs ? s_peer_tdata : s_local_tdata;
  assign src_last       = peer_hs ? s_peer_tlast : s_local_tlast;
  // word_cnt_q counts words already taken, so the limit word is the one seen at LAST
  assign at_limit       = (word_cnt_q == WORD_LAST);
  assign frame_end      = hs && (src_last || at_limit);
  assign trunc          = hs && at_limit && !src_last;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    word_cnt_d  = word_cnt_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    peer_cnt_d  = peer_cnt_q;
    local_cnt_d = local_cnt_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        word_cnt_d = '0;
        if (i_sfp_en) begin
          if (s_peer_tvalid && ((starve_q < STARVE_MAX) || !s_local_tvalid)) begin
            state_d = ST_PEER;
          end else if (s_local_tvalid) begin
            state_d = ST_LOCAL;
          end
        end
      end
      ST_PEER, ST_LOCAL: begin
        if (frame_end) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (hs) begin
      word_cnt_d = word_cnt_q + 5'd1;
      tdata_d    = src_data;
      tvalid_d   = 1'b1;
      tlast_d    = src_last || at_limit;
    end else if (m_tx_sfp_tready) begin
      tvalid_d = 1'b0;
    end

    if (frame_end && peer_hs) begin
      peer_cnt_d = peer_cnt_q + 16'd1;
      if (!s_local_tvalid) begin
        starve_d = '0;
      end else if (starve_q != STARVE_MAX) begin
        starve_d = starve_q + 1'b1;
      end
    end
    if (frame_end && local_hs) begin
      local_cnt_d = local_cnt_q + 16'd1;
      starve_d    = '0;
    end

    if (i_err_clr) begin
      err_d = 1'b0;
    end
    if (trunc) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      word_cnt_q  <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      peer_cnt_q  <= '0;
      local_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      word_cnt_q  <= word_cnt_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      peer_cnt_q  <= peer_cnt_d;
      local_cnt_q <= local_cnt_d;
      err_q       <= err_d;
    end
  end

  assign m_tx_sfp_tdata    = tdata_q;
  assign m_tx_sfp_tvalid   = tvalid_q;
  assign m_tx_sfp_tlast    = tlast_q;
  assign o_peer_frame_cnt  = peer_cnt_q;
  assign o_local_frame_cnt = local_cnt_q;
  assign o_err_long        = err_q;
  assign o_state           = state_q;

endmodule

// File: tb/tb_sfp_tx_arbiter.sv
// tb/tb_sfp_tx_arbiter.sv - directed bench for sfp_tx_arbiter
// Cycle table for a single local frame, then queue-driven sequences for multi-frame cases.
module tb_sfp_tx_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst, i_sfp_en, i_err_clr;
  logic [63:0] s_peer_tdata, s_local_tdata, m_tx_sfp_tdata;
  logic        s_peer_tvalid, s_peer_tlast, s_peer_tready;
  logic        s_local_tvalid, s_local_tlast, s_local_tready;
  logic        m_tx_sfp_tvalid, m_tx_sfp_tlast, m_tx_sfp_tready;
  logic [15:0] o_peer_frame_cnt, o_local_frame_cnt;
  logic        o_err_long;
  logic [1:0]  o_state;

  always #5 i_clk = ~i_clk;

  sfp_tx_arbiter #(.STARVE_LIMIT(4), .MAX_FRAME_WORDS(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sfp_en(i_sfp_en), .i_err_clr(i_err_clr),
    .s_peer_tdata(s_peer_tdata), .s_peer_tvalid(s_peer_tvalid),
    .s_peer_tlast(s_peer_tlast), .s_peer_tready(s_peer_tready),
    .s_local_tdata(s_local_tdata), .s_local_tvalid(s_local_tvalid),
    .s_local_tlast(s_local_tlast), .s_local_tready(s_local_tready),
    .m_tx_sfp_tdata(m_tx_sfp_tdata), .m_tx_sfp_tvalid(m_tx_sfp_tvalid),
    .m_tx_sfp_tlast(m_tx_sfp_tlast), .m_tx_sfp_tready(m_tx_sfp_tready),
    .o_peer_frame_cnt(o_peer_frame_cnt), .o_local_frame_cnt(o_local_frame_cnt),
    .o_err_long(o_err_long), .o_state(o_state)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } word_t;

  typedef struct packed {
    logic        lv;
    logic [63:0] ld;
    logic        ll;
    logic [1:0]  st;
    logic        lrdy;
    logic        mv;
    logic [63:0] md;
    logic        ml;
    logic [15:0] lcnt;
  } vec_t;

  int    n_vec = 0;
  int    n_bad = 0;
  word_t pq[$], lq[$], out_q[$], exp_q[$];
  int    pi, li, cyc;
  logic  sink_toggle;
  logic  stall_prev, stall_last;
  logic [63:0] stall_data;
  vec_t  tbl[12];

  function automatic logic [63:0] pw(int f, int w);
    return 64'hB000_0000_0000_0000 | 64'(f * 16 + w);
  endfunction

  function automatic logic [63:0] lw(int f, int w);
    return 64'hC000_0000_0000_0000 | 64'(f * 32 + w);
  endfunction

  function automatic word_t mkw(logic [63:0] d, logic l);
    word_t w;
    w.data = d;
    w.last = l;
    return w;
  endfunction

  function automatic vec_t mkv(logic lv, logic [63:0] ld, logic ll, logic [1:0] st,
                               logic lrdy, logic mv, logic [63:0] md, logic ml, logic [15:0] lcnt);
    vec_t v;
    v.lv = lv; v.ld = ld; v.ll = ll; v.st = st; v.lrdy = lrdy;
    v.mv = mv; v.md = md; v.ml = ml; v.lcnt = lcnt;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    s_peer_tvalid  = (pi < pq.size());
    s_peer_tdata   = s_peer_tvalid ? pq[pi].data : 64'd0;
    s_peer_tlast   = s_peer_tvalid ? pq[pi].last : 1'b0;
    s_local_tvalid = (li < lq.size());
    s_local_tdata  = s_local_tvalid ? lq[li].data : 64'd0;
    s_local_tlast  = s_local_tvalid ? lq[li].last : 1'b0;
    m_tx_sfp_tready = sink_toggle ? (cyc % 2 == 0) : 1'b1;
  endtask

  task automatic step();
    logic p_adv, l_adv;
    #1;
    p_adv = s_peer_tvalid && s_peer_tready;
    l_adv = s_local_tvalid && s_local_tready;
    if (stall_prev) begin
      chk("hold_valid", 64'(m_tx_sfp_tvalid), 64'd1);
      chk("hold_data", m_tx_sfp_tdata, stall_data);
      chk("hold_last", 64'(m_tx_sfp_tlast), 64'(stall_last));
    end
    stall_prev = m_tx_sfp_tvalid && !m_tx_sfp_tready;
    stall_data = m_tx_sfp_tdata;
    stall_last = m_tx_sfp_tlast;
    if (m_tx_sfp_tvalid && m_tx_sfp_tready) out_q.push_back(mkw(m_tx_sfp_tdata, m_tx_sfp_tlast));
    @(posedge i_clk);
    @(negedge i_clk);
    cyc++;
    if (p_adv) pi++;
    if (l_adv) li++;
    drive();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    pq.delete(); lq.delete(); out_q.delete(); exp_q.delete();
    pi = 0; li = 0; cyc = 0;
    stall_prev = 1'b0; sink_toggle = 1'b0;
    i_sfp_en = 1'b1; i_err_clr = 1'b0;
    drive();
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    drive();
  endtask

  task automatic run_until_out(int n, int budget);
    int k = 0;
    while (out_q.size() < n && k < budget) begin
      step();
      k++;
    end
    if (out_q.size() < n) chk("timeout_words", 64'(out_q.size()), 64'(n));
  endtask

  task automatic cmp_out(string name);
    chk({name, "_count"}, 64'(out_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_data[%0d]", name, i), out_q[i].data, exp_q[i].data);
      chk($sformatf("%s_last[%0d]", name, i), 64'(out_q[i].last), 64'(exp_q[i].last));
    end
  endtask

  initial begin
    tbl[0]  = mkv(1, lw(0, 0), 0, 2'd0, 0, 0, 64'd0, 0, 16'd0);
    tbl[1]  = mkv(1, lw(0, 0), 0, 2'd2, 1, 0, 64'd0, 0, 16'd0);
    tbl[2]  = mkv(1, lw(0, 1), 0, 2'd2, 1, 1, lw(0, 0), 0, 16'd0);
    tbl[3]  = mkv(1, lw(0, 2), 0, 2'd2, 1, 1, lw(0, 1), 0, 16'd0);
    tbl[4]  = mkv(1, lw(0, 3), 0, 2'd2, 1, 1, lw(0, 2), 0, 16'd0);
    tbl[5]  = mkv(1, lw(0, 4), 0, 2'd2, 1, 1, lw(0, 3), 0, 16'd0);
    tbl[6]  = mkv(1, lw(0, 5), 0, 2'd2, 1, 1, lw(0, 4), 0, 16'd0);
    tbl[7]  = mkv(1, lw(0, 6), 0, 2'd2, 1, 1, lw(0, 5), 0, 16'd0);
    tbl[8]  = mkv(1, lw(0, 7), 0, 2'd2, 1, 1, lw(0, 6), 0, 16'd0);
    tbl[9]  = mkv(1, lw(0, 8), 1, 2'd2, 1, 1, lw(0, 7), 0, 16'd0);
    tbl[10] = mkv(0, 64'd0,    0, 2'd0, 0, 1, lw(0, 8), 1, 16'd1);
    tbl[11] = mkv(0, 64'd0,    0, 2'd0, 0, 0, 64'd0,    0, 16'd1);

    // reset values
    do_reset();
    #1;
    chk("rst_state", 64'(o_state), 64'd0);
    chk("rst_tvalid", 64'(m_tx_sfp_tvalid), 64'd0);
    chk("rst_tdata", m_tx_sfp_tdata, 64'd0);
    chk("rst_tlast", 64'(m_tx_sfp_tlast), 64'd0);
    chk("rst_peer_cnt", 64'(o_peer_frame_cnt), 64'd0);
    chk("rst_local_cnt", 64'(o_local_frame_cnt), 64'd0);
    chk("rst_err", 64'(o_err_long), 64'd0);

    // single 9-word local frame, cycle by cycle
    do_reset();
    for (int r = 0; r < 12; r++) begin
      s_peer_tvalid = 1'b0; s_peer_tdata = 64'd0; s_peer_tlast = 1'b0;
      s_local_tvalid = tbl[r].lv; s_local_tdata = tbl[r].ld; s_local_tlast = tbl[r].ll;
      m_tx_sfp_tready = 1'b1;
      #1;
      chk($sformatf("tbl_state[%0d]", r), 64'(o_state), 64'(tbl[r].st));
      chk($sformatf("tbl_lready[%0d]", r), 64'(s_local_tready), 64'(tbl[r].lrdy));
      chk($sformatf("tbl_pready[%0d]", r), 64'(s_peer_tready), 64'd0);
      chk($sformatf("tbl_mvalid[%0d]", r), 64'(m_tx_sfp_tvalid), 64'(tbl[r].mv));
      if (tbl[r].mv) begin
        chk($sformatf("tbl_mdata[%0d]", r), m_tx_sfp_tdata, tbl[r].md);
        chk($sformatf("tbl_mlast[%0d]", r), 64'(m_tx_sfp_tlast), 64'(tbl[r].ml));
      end
      chk($sformatf("tbl_lcnt[%0d]", r), 64'(o_local_frame_cnt), 64'(tbl[r].lcnt));
      @(posedge i_clk);
      @(negedge i_clk);
    end

    // starvation: both sources always valid, 2-word frames
    do_reset();
    for (int f = 0; f < 10; f++) begin
      pq.push_back(mkw(pw(f, 0), 1'b0)); pq.push_back(mkw(pw(f, 1), 1'b1));
      lq.push_back(mkw(lw(f, 0), 1'b0)); lq.push_back(mkw(lw(f, 1), 1'b1));
    end
    begin
      int pf = 0, lf = 0;
      for (int g = 0; g < 10; g++) begin
        if (g == 4 || g == 9) begin
          exp_q.push_back(mkw(lw(lf, 0), 1'b0)); exp_q.push_back(mkw(lw(lf, 1), 1'b1)); lf++;
        end else begin
          exp_q.push_back(mkw(pw(pf, 0), 1'b0)); exp_q.push_back(mkw(pw(pf, 1), 1'b1)); pf++;
        end
      end
    end
    drive();
    run_until_out(20, 300);
    cmp_out("starve");
    chk("starve_peer_cnt", 64'(o_peer_frame_cnt), 64'd8);
    chk("starve_local_cnt", 64'(o_local_frame_cnt), 64'd2);

    // backpressure: sink ready toggles during a 3-word peer frame
    do_reset();
    sink_toggle = 1'b1;
    for (int w = 0; w < 3; w++) pq.push_back(mkw(pw(0, w), w == 2));
    for (int w = 0; w < 3; w++) exp_q.push_back(mkw(pw(0, w), w == 2));
    drive();
    run_until_out(3, 60);
    for (int k = 0; k < 4; k++) step();
    cmp_out("bp");
    chk("bp_peer_cnt", 64'(o_peer_frame_cnt), 64'd1);

    // 20-word local stream without tlast: truncation at word 16
    do_reset();
    for (int w = 0; w < 20; w++) lq.push_back(mkw(lw(1, w), 1'b0));
    for (int w = 0; w < 20; w++) exp_q.push_back(mkw(lw(1, w), w == 15));
    drive();
    run_until_out(20, 100);
    cmp_out("long");
    chk("long_err", 64'(o_err_long), 64'd1);
    chk("long_local_cnt", 64'(o_local_frame_cnt), 64'd1);
    chk("long_state", 64'(o_state), 64'd2);
    i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0;
    #1;
    chk("long_err_cleared", 64'(o_err_long), 64'd0);

    // truncation wins over a simultaneous clear
    do_reset();
    for (int w = 0; w < 17; w++) lq.push_back(mkw(lw(2, w), 1'b0));
    i_err_clr = 1'b1;
    drive();
    begin
      int k = 0;
      while (li < 16 && k < 60) begin
        step();
        k++;
      end
    end
    #1;
    chk("clr_prio_err_set", 64'(o_err_long), 64'd1);
    step();
    #1;
    chk("clr_prio_err_clr", 64'(o_err_long), 64'd0);
    i_err_clr = 1'b0;

    // enable drops during a 5-word peer frame with a local frame pending
    do_reset();
    for (int w = 0; w < 5; w++) pq.push_back(mkw(pw(3, w), w == 4));
    for (int w = 0; w < 9; w++) lq.push_back(mkw(lw(3, w), w == 8));
    for (int w = 0; w < 5; w++) exp_q.push_back(mkw(pw(3, w), w == 4));
    drive();
    begin
      int k = 0;
      while (pi < 2 && k < 20) begin
        step();
        k++;
      end
    end
    i_sfp_en = 1'b0;
    for (int k = 0; k < 20; k++) step();
    #1;
    cmp_out("en_drop");
    chk("en_drop_state", 64'(o_state), 64'd0);
    chk("en_drop_lready", 64'(s_local_tready), 64'd0);
    chk("en_drop_peer_cnt", 64'(o_peer_frame_cnt), 64'd1);
    chk("en_drop_local_cnt", 64'(o_local_frame_cnt), 64'd0);
    i_sfp_en = 1'b1;
    for (int w = 0; w < 9; w++) exp_q.push_back(mkw(lw(3, w), w == 8));
    run_until_out(14, 80);
    cmp_out("en_resume");
    chk("en_resume_local_cnt", 64'(o_local_frame_cnt), 64'd1);

    // reset asserted during word 3 of the second peer frame
    do_reset();
    pq.push_back(mkw(pw(4, 0), 1'b0)); pq.push_back(mkw(pw(4, 1), 1'b1));
    for (int w = 0; w < 5; w++) pq.push_back(mkw(pw(5, w), w == 4));
    drive();
    begin
      int k = 0;
      while (pi < 4 && k < 40) begin
        step();
        k++;
      end
    end
    #1;
    chk("pre_rst_peer_cnt", 64'(o_peer_frame_cnt), 64'd1);
    chk("pre_rst_tvalid", 64'(m_tx_sfp_tvalid), 64'd1);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_state", 64'(o_state), 64'd0);
    chk("mid_rst_tvalid", 64'(m_tx_sfp_tvalid), 64'd0);
    chk("mid_rst_tdata", m_tx_sfp_tdata, 64'd0);
    chk("mid_rst_tlast", 64'(m_tx_sfp_tlast), 64'd0);
    chk("mid_rst_pready", 64'(s_peer_tready), 64'd0);
    chk("mid_rst_lready", 64'(s_local_tready), 64'd0);
    chk("mid_rst_peer_cnt", 64'(o_peer_frame_cnt), 64'd0);
    chk("mid_rst_local_cnt", 64'(o_local_frame_cnt), 64'd0);
    chk("mid_rst_err", 64'(o_err_long), 64'd0);
    @(negedge i_clk);
    do_reset();
    lq.push_back(mkw(lw(6, 0), 1'b0)); lq.push_back(mkw(lw(6, 1), 1'b1));
    exp_q.push_back(mkw(lw(6, 0), 1'b0)); exp_q.push_back(mkw(lw(6, 1), 1'b1));
    drive();
    run_until_out(2, 30);
    cmp_out("post_rst");
    chk("post_rst_local_cnt", 64'(o_local_frame_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
